// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - slot layout, field offsets and slot structs for the sprite compositor
package sprite_pkg;

   localparam int SLOT_W    = 32;
   localparam int COORD_W   = 10;
   localparam int STATE_W   = 6;
   localparam int OFF_W     = 6;

   // Bit offsets of each field inside one 32-bit slot of state_in
   localparam int X_LSB     = 0;
   localparam int Y_LSB     = 10;
   localparam int EN_BIT    = 20;
   localparam int STATE_LSB = 21;

   // Full slot as it appears on state_in
   typedef struct packed {
      logic [4:0]         rsvd;
      logic [STATE_W-1:0] state;
      logic               en;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } slot_t;

   // Fields actually held in the shadow registers
   typedef struct packed {
      logic [STATE_W-1:0] state;
      logic               en;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } sprite_t;

endpackage

// File: rtl/sprite_box_test.sv
// rtl/sprite_box_test.sv - one slot's bounding-box coverage test
module sprite_box_test
   import sprite_pkg::*;
#(
   parameter int SPRITE_W = 40,
   parameter int SPRITE_H = 40
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic               en,
   input  logic [COORD_W-1:0] draw_x,
   input  logic [COORD_W-1:0] draw_y,
   output logic               inbox
);

   // Bounds are one bit wider than coordinates so a box near 1023 does not wrap to column 0
   logic [COORD_W:0] hi_x;
   logic [COORD_W:0] hi_y;

   // Pixel is inside when x <= draw_x < x+W and y <= draw_y < y+H
   always_comb begin
      hi_x  = {1'b0, x} + (COORD_W+1)'(SPRITE_W);
      hi_y  = {1'b0, y} + (COORD_W+1)'(SPRITE_H);
      inbox = en
            && ({1'b0, draw_x} >= {1'b0, x}) && ({1'b0, draw_x} < hi_x)
            && ({1'b0, draw_y} >= {1'b0, y}) && ({1'b0, draw_y} < hi_y);
   end

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - two-stage sprite hit pipeline with frame-latched slots and collision map
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter  int NUM_SPRITES = 10,
   parameter  int SPRITE_W    = 40,
   parameter  int SPRITE_H    = 40,
   parameter  int H_VIS       = 640,
   parameter  int V_VIS       = 480,
   localparam int IDX_W       = $clog2(NUM_SPRITES)
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic                          frame_clk,
   input  logic [COORD_W-1:0]            DrawX,
   input  logic [COORD_W-1:0]            DrawY,
   input  logic [NUM_SPRITES*SLOT_W-1:0] state_in,
   output logic                          hit,
   output logic [IDX_W-1:0]              hit_idx,
   output logic [OFF_W-1:0]              off_x,
   output logic [OFF_W-1:0]              off_y,
   output logic [STATE_W-1:0]            hit_state,
   output logic [NUM_SPRITES-1:0]        collide,
   output logic                          collide_valid
);

   logic                   frame_q, frame_d;
   logic                   frame_edge;
   sprite_t                shadow_q [NUM_SPRITES];
   sprite_t                shadow_d [NUM_SPRITES];

   logic [NUM_SPRITES-1:0] inbox_c;
   logic [NUM_SPRITES-1:0] inbox_q, inbox_d;
   logic [COORD_W-1:0]     s1_x_q [NUM_SPRITES];
   logic [COORD_W-1:0]     s1_x_d [NUM_SPRITES];
   logic [COORD_W-1:0]     s1_y_q [NUM_SPRITES];
   logic [COORD_W-1:0]     s1_y_d [NUM_SPRITES];
   logic [STATE_W-1:0]     s1_st_q [NUM_SPRITES];
   logic [STATE_W-1:0]     s1_st_d [NUM_SPRITES];
   logic [COORD_W-1:0]     draw_x_q, draw_x_d;
   logic [COORD_W-1:0]     draw_y_q, draw_y_d;
   logic                   vis_q, vis_d;

   logic [IDX_W-1:0]       win;
   logic [NUM_SPRITES-1:0] contrib;
   logic                   hit_q, hit_d;
   logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
   logic [OFF_W-1:0]       off_x_q, off_x_d;
   logic [OFF_W-1:0]       off_y_q, off_y_d;
   logic [STATE_W-1:0]     hit_state_q, hit_state_d;
   logic [NUM_SPRITES-1:0] acc_q, acc_d;
   logic [NUM_SPRITES-1:0] collide_q, collide_d;
   logic                   collide_valid_q, collide_valid_d;

   // Reserved slot bits carry no meaning here
   logic unused_state_in;
   assign unused_state_in = ^state_in;

   // Falling edge of vsync: high last cycle, low now
   assign frame_edge = frame_q & ~frame_clk;

   // Frame latch: slots are only taken from state_in on a frame edge, so a frame never tears
   always_comb begin
      frame_d = frame_clk;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_d[i] = shadow_q[i];
         if (frame_edge) begin
            shadow_d[i].x     = state_in[i*SLOT_W + X_LSB +: COORD_W];
            shadow_d[i].y     = state_in[i*SLOT_W + Y_LSB +: COORD_W];
            shadow_d[i].en    = state_in[i*SLOT_W + EN_BIT];
            shadow_d[i].state = state_in[i*SLOT_W + STATE_LSB +: STATE_W];
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_box
      sprite_box_test #(
         .SPRITE_W (SPRITE_W),
         .SPRITE_H (SPRITE_H)
      ) u_box (
         .x      (shadow_q[g].x),
         .y      (shadow_q[g].y),
         .en     (shadow_q[g].en),
         .draw_x (DrawX),
         .draw_y (DrawY),
         .inbox  (inbox_c[g])
      );
   end

   // Stage 1: capture per-slot coverage plus the slot fields stage 2 needs, so a shadow update in between cannot skew the winner
   always_comb begin
      inbox_d  = inbox_c;
      draw_x_d = DrawX;
      draw_y_d = DrawY;
      vis_d    = ({1'b0, DrawX} < (COORD_W+1)'(H_VIS)) && ({1'b0, DrawY} < (COORD_W+1)'(V_VIS));
      for (int i = 0; i < NUM_SPRITES; i++) begin
         s1_x_d[i]  = shadow_q[i].x;
         s1_y_d[i]  = shadow_q[i].y;
         s1_st_d[i] = shadow_q[i].state;
      end
   end

   // Stage 2: lowest-index winner, offsets, and collision accumulation across the frame
   always_comb begin
      win = '0;
      for (int i = NUM_SPRITES-1; i >= 0; i--) begin
         if (inbox_q[i]) win = IDX_W'(i);
      end
      hit_d       = |inbox_q;
      hit_idx_d   = '0;
      off_x_d     = '0;
      off_y_d     = '0;
      hit_state_d = '0;
      if (hit_d) begin
         hit_idx_d   = win;
         off_x_d     = OFF_W'(draw_x_q - s1_x_q[win]);
         off_y_d     = OFF_W'(draw_y_q - s1_y_q[win]);
         hit_state_d = s1_st_q[win];
      end
      contrib = (vis_q && ($countones(inbox_q) >= 2)) ? inbox_q : '0;
      // A contribution landing on the frame edge belongs to the frame that is just starting
      acc_d           = frame_edge ? contrib : (acc_q | contrib);
      collide_d       = frame_edge ? acc_q : collide_q;
      collide_valid_d = frame_edge;
   end

   // State registers; reset empties every slot and forgets any partial collision data
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_q         <= 1'b1;
         inbox_q         <= '0;
         draw_x_q        <= '0;
         draw_y_q        <= '0;
         vis_q           <= 1'b0;
         hit_q           <= 1'b0;
         hit_idx_q       <= '0;
         off_x_q         <= '0;
         off_y_q         <= '0;
         hit_state_q     <= '0;
         acc_q           <= '0;
         collide_q       <= '0;
         collide_valid_q <= 1'b0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
            s1_x_q[i]   <= '0;
            s1_y_q[i]   <= '0;
            s1_st_q[i]  <= '0;
         end
      end else begin
         frame_q         <= frame_d;
         inbox_q         <= inbox_d;
         draw_x_q        <= draw_x_d;
         draw_y_q        <= draw_y_d;
         vis_q           <= vis_d;
         hit_q           <= hit_d;
         hit_idx_q       <= hit_idx_d;
         off_x_q         <= off_x_d;
         off_y_q         <= off_y_d;
         hit_state_q     <= hit_state_d;
         acc_q           <= acc_d;
         collide_q       <= collide_d;
         collide_valid_q <= collide_valid_d;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= shadow_d[i];
            s1_x_q[i]   <= s1_x_d[i];
            s1_y_q[i]   <= s1_y_d[i];
            s1_st_q[i]  <= s1_st_d[i];
         end
      end
   end

   assign hit           = hit_q;
   assign hit_idx       = hit_idx_q;
   assign off_x         = off_x_q;
   assign off_y         = off_y_q;
   assign hit_state     = hit_state_q;
   assign collide       = collide_q;
   assign collide_valid = collide_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed table and sequence checks for sprite_compositor
module tb_sprite_compositor;

   localparam int N = 10;

   logic           Clk = 1'b0;
   logic           Reset_n;
   logic           frame_clk;
   logic [9:0]     DrawX;
   logic [9:0]     DrawY;
   logic [N*32-1:0] state_in;
   logic           hit;
   logic [3:0]     hit_idx;
   logic [5:0]     off_x;
   logic [5:0]     off_y;
   logic [5:0]     hit_state;
   logic [N-1:0]   collide;
   logic           collide_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int dx; int dy; int h; int idx; int ox; int oy; int st;
   } vec_t;
   vec_t vecs [11];

   sprite_compositor #(
      .NUM_SPRITES (N),
      .SPRITE_W    (40),
      .SPRITE_H    (40),
      .H_VIS       (640),
      .V_VIS       (480)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .frame_clk     (frame_clk),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .state_in      (state_in),
      .hit           (hit),
      .hit_idx       (hit_idx),
      .off_x         (off_x),
      .off_y         (off_y),
      .hit_state     (hit_state),
      .collide       (collide),
      .collide_valid (collide_valid)
   );

   always #10 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int eh, input int ei, input int eox, input int eoy, input int est);
      chk({tag, ".hit"},       int'(hit),       eh);
      chk({tag, ".hit_idx"},   int'(hit_idx),   ei);
      chk({tag, ".off_x"},     int'(off_x),     eox);
      chk({tag, ".off_y"},     int'(off_y),     eoy);
      chk({tag, ".hit_state"}, int'(hit_state), est);
   endtask

   task automatic set_slot(input int i, input int x, input int y, input int en, input int st);
      state_in[i*32 +: 32] = {5'd0, 6'(st), 1'(en), 10'(y), 10'(x)};
   endtask

   // Drive a pixel and wait until its result is on the outputs
   task automatic pixel(input int x, input int y);
      @(negedge Clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      repeat (2) @(negedge Clk);
   endtask

   task automatic frame_pulse(input string tag, input int exp_col);
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
      frame_clk = 1'b1;
      chk({tag, ".valid"},   int'(collide_valid), 1);
      chk({tag, ".collide"}, int'(collide),       exp_col);
      @(negedge Clk);
      chk({tag, ".valid_drop"}, int'(collide_valid), 0);
   endtask

   initial begin
      vecs[0]  = '{100,  50, 1, 0,  0,  0,  5};
      vecs[1]  = '{139,  89, 1, 0, 39, 39,  5};
      vecs[2]  = '{140,  50, 0, 0,  0,  0,  0};
      vecs[3]  = '{120,  60, 1, 0, 20, 10,  5};
      vecs[4]  = '{145,  90, 1, 3, 35, 35,  9};
      vecs[5]  = '{1000, 300, 1, 5,  0,  0, 33};
      vecs[6]  = '{1023, 339, 1, 5, 23, 39, 33};
      vecs[7]  = '{5,   300, 0, 0,  0,  0,  0};
      vecs[8]  = '{700, 120, 1, 7, 20, 20, 12};
      vecs[9]  = '{300, 200, 0, 0,  0,  0,  0};
      vecs[10] = '{0,     0, 0, 0,  0,  0,  0};

      Reset_n   = 1'b0;
      frame_clk = 1'b1;
      DrawX     = '0;
      DrawY     = '0;
      state_in  = '0;
      repeat (3) @(negedge Clk);
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset.collide", int'(collide), 0);
      chk("reset.valid", int'(collide_valid), 0);
      Reset_n = 1'b1;

      set_slot(0, 100, 50, 1, 5);
      set_slot(2, 300, 200, 0, 7);
      set_slot(3, 110, 55, 1, 9);
      set_slot(5, 1000, 300, 1, 33);
      set_slot(7, 680, 100, 1, 12);
      set_slot(8, 680, 100, 1, 13);
      frame_pulse("frame1", 0);

      for (int v = 0; v < 11; v++) begin
         pixel(vecs[v].dx, vecs[v].dy);
         chk_out($sformatf("vec%0d", v), vecs[v].h, vecs[v].idx, vecs[v].ox, vecs[v].oy, vecs[v].st);
      end

      // Visible overlaps of slots 0 and 3 count; the invisible 7/8 overlap does not
      set_slot(0, 200, 50, 1, 5);
      pixel(100, 50);
      chk_out("tear_old", 1, 0, 0, 0, 5);
      pixel(200, 50);
      chk_out("tear_new_early", 0, 0, 0, 0, 0);
      set_slot(4, 110, 55, 1, 20);
      frame_pulse("frame2", 10'h009);
      pixel(200, 50);
      chk_out("moved_new", 1, 0, 0, 0, 5);
      pixel(100, 50);
      chk_out("moved_old", 0, 0, 0, 0, 0);

      // Overlap reaching stage 2 on the very cycle of the frame edge
      @(negedge Clk);
      DrawX = 10'd120;
      DrawY = 10'd60;
      @(negedge Clk);
      DrawX = 10'd0;
      DrawY = 10'd0;
      frame_clk = 1'b0;
      @(negedge Clk);
      frame_clk = 1'b1;
      chk("edge_same.valid", int'(collide_valid), 1);
      chk("edge_same.collide", int'(collide), 0);
      chk_out("edge_same", 1, 3, 10, 5, 9);
      @(negedge Clk);
      chk("edge_same.valid_drop", int'(collide_valid), 0);
      repeat (3) @(negedge Clk);
      frame_pulse("frame_after_edge", 10'h018);

      // Reset in the middle of a frame with collisions pending
      pixel(120, 60);
      chk_out("pre_reset", 1, 3, 10, 5, 9);
      @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      chk_out("mid_reset", 0, 0, 0, 0, 0);
      chk("mid_reset.collide", int'(collide), 0);
      chk("mid_reset.valid", int'(collide_valid), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      pixel(120, 60);
      chk_out("post_reset_empty", 0, 0, 0, 0, 0);
      frame_pulse("frame_post_reset", 0);
      pixel(120, 60);
      chk_out("post_reset_reload", 1, 3, 10, 5, 9);
      pixel(0, 0);
      frame_pulse("frame_final", 10'h018);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
